fft8_mag_peak: RTL and testbench
================================

# fft8_mag_peak

Post-processing stage directly downstream of the 8-point FFT core. It captures the eight complex bins X0..X7 (32-bit signed re/im) when the core pulses done. It then computes an approximate magnitude per bin, one bin per clock, and tracks the peak bin. Results are presented with a busy/done handshake for the display/UART stage.

## Interface
Parameters:
- P_SKIP_DC, 1: when 1, bin 0 is excluded from the peak search (its magnitude is still computed).

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  capture request; wired to the FFT core done pulse
- i_X0_re … i_X7_re  in  32 each  signed real part of bin k
- i_X0_im … i_X7_im  in  32 each  signed imaginary part of bin k
- o_busy  out  1  high while capturing/scanning
- o_done  out  1  one-cycle pulse when all outputs are valid
- o_mag0 … o_mag7  out  33 each  unsigned magnitude estimate of bin k
- o_peak_idx  out  3  index of largest magnitude in the search range
- o_peak_mag  out  33  magnitude of o_peak_idx

## Operation
- Clock and reset: i_clk is the clock. i_rstn is an asynchronous, active-low reset.
- States: ST_IDLE, ST_SCAN, ST_DONE. A 3-bit bin counter cnt is used in ST_SCAN.
- ST_IDLE:
  - If i_start=1, latch all 16 inputs into internal registers.
  - Clear the running peak (pk_mag=0, pk_idx=P_SKIP_DC ? 1 : 0).
  - Set cnt=0, o_busy=1, and go to ST_SCAN.
- ST_SCAN:
  - Each cycle, compute the magnitude of latched bin cnt and write o_mag[cnt].
  - If the bin is in the search range (cnt≥1 when P_SKIP_DC=1) and mag > pk_mag (strict), update pk_mag=mag and pk_idx=cnt. Ties therefore keep the lowest index.
  - When cnt=7, copy the final peak into o_peak_idx/o_peak_mag (including the bin-7 update), drop o_busy, and go to ST_DONE. Otherwise cnt+1.
- ST_DONE: o_done=1 for this one cycle, then return to ST_IDLE.
- Magnitude (alpha-max-plus-beta-min, α=1, β=3/8):
  - a=|re|, b=|im|, each 33-bit unsigned. |−2^31| = 2^31 exactly, with no saturation.
  - mx=max(a,b), mn=min(a,b).
  - mag = mx + (mn>>2) + (mn>>3), with floor shifts.
  - The maximum is 1.375·2^31 < 2^33, so no overflow is possible.
- i_start is ignored in ST_SCAN and ST_DONE; no queuing.
- Mid-scan rules:
  - o_mag registers update progressively during ST_SCAN. Consumers must sample them only on o_done.
  - o_peak_idx/o_peak_mag change only at the ST_SCAN→ST_DONE transition, so they are stable otherwise.

## Timing
- Reset values: state=ST_IDLE, o_busy=0, o_done=0, all o_mag=0, o_peak_idx=0, o_peak_mag=0, internal latches/peak/cnt=0.
- Cycle numbering:
  - Edge E0 samples i_start=1: o_busy=1 after E0.
  - Edges E1..E8 process bins 0..7. o_magk is valid after edge E(k+1).
  - After E8: o_peak_* valid, o_busy=0.
  - After E9: o_done=1. After E10: o_done=0, and the block is in ST_IDLE and accepts i_start.
- Latency from i_start to o_done rising is 9 clocks. Minimum start-to-start spacing is 10 clocks.
- Because the FFT core's done pulse lasts one cycle and its outputs are held, back-to-back frames from the core, which are at most one per 3 clocks, must be throttled upstream. Extra starts are dropped.
- Reset mid-scan: all outputs return to reset values immediately (asynchronously). No o_done is issued for the aborted frame.
- If i_start=1 in the same cycle as ST_DONE, it is ignored. A start is accepted in the next ST_IDLE cycle only if still asserted.

## Test plan
- Reset check: assert i_rstn=0 mid-operation -> all outputs 0 immediately. Release -> state IDLE, o_busy=0.
- Flat spectrum: all re=100, im=0, P_SKIP_DC=1 -> all o_mag=100, o_peak_idx=1 (tie → lowest index), o_peak_mag=100. o_busy high after E0 and low after E8, o_done high exactly one cycle after E9.
- Mixed signs: X3=(−300,+400), others 0 -> o_mag3=400+75+37=512, others 0, o_peak_idx=3, o_peak_mag=512. X5=(−7,0) in a second run -> o_mag5=7, peak 5.
- Extremes: X6=(−2^31,−2^31), others 0 -> o_mag6=2^31+2^29+2^28=2952790016, peak 6. X2=(2^31−1,0) -> o_mag2=2147483647.
- DC handling: X0=(1000,0), X4=(0,500), others 0 -> P_SKIP_DC=1 gives peak 4/500; P_SKIP_DC=0 gives peak 0/1000.
- Handshake: pulse i_start at E0, again at E3 and at E9 with different data -> the later pulses are ignored. Outputs reflect the first frame only, with exactly one o_done. A start at E11 is accepted normally.

Source files
------------

// File: rtl/fft8_mag_peak.sv
// Post-FFT stage: latches eight complex bins, computes an alpha-max-plus-beta-min
// magnitude per bin (one bin per clock) and reports the peak bin with a busy/done handshake.
module fft8_mag_peak #(
   parameter bit P_SKIP_DC = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_start,
   input  logic [31:0] i_X0_re,
   input  logic [31:0] i_X1_re,
   input  logic [31:0] i_X2_re,
   input  logic [31:0] i_X3_re,
   input  logic [31:0] i_X4_re,
   input  logic [31:0] i_X5_re,
   input  logic [31:0] i_X6_re,
   input  logic [31:0] i_X7_re,
   input  logic [31:0] i_X0_im,
   input  logic [31:0] i_X1_im,
   input  logic [31:0] i_X2_im,
   input  logic [31:0] i_X3_im,
   input  logic [31:0] i_X4_im,
   input  logic [31:0] i_X5_im,
   input  logic [31:0] i_X6_im,
   input  logic [31:0] i_X7_im,
   output logic        o_busy,
   output logic        o_done,
   output logic [32:0] o_mag0,
   output logic [32:0] o_mag1,
   output logic [32:0] o_mag2,
   output logic [32:0] o_mag3,
   output logic [32:0] o_mag4,
   output logic [32:0] o_mag5,
   output logic [32:0] o_mag6,
   output logic [32:0] o_mag7,
   output logic [2:0]  o_peak_idx,
   output logic [32:0] o_peak_mag,
   output logic [1:0]  o_dbg_state
);

   // Handshake: i_start is sampled only in ST_IDLE; o_busy is high from the
   // accepting edge until the edge that finishes bin 7; o_done then pulses for
   // exactly one cycle, and all o_mag*/o_peak_* are valid while it is high.

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [31:0] in_re  [8];
   logic [31:0] in_im  [8];
   logic [31:0] lat_re [8];
   logic [31:0] lat_im [8];
   logic [32:0] mag_q  [8];
   logic [32:0] pk_mag;
   logic [2:0]  pk_idx;

   logic [32:0] abs_re;
   logic [32:0] abs_im;
   logic [32:0] mx;
   logic [32:0] mn;
   logic [32:0] cur_mag;
   logic        in_range;
   logic [32:0] nxt_pk_mag;
   logic [2:0]  nxt_pk_idx;

   assign in_re[0] = i_X0_re;
   assign in_re[1] = i_X1_re;
   assign in_re[2] = i_X2_re;
   assign in_re[3] = i_X3_re;
   assign in_re[4] = i_X4_re;
   assign in_re[5] = i_X5_re;
   assign in_re[6] = i_X6_re;
   assign in_re[7] = i_X7_re;
   assign in_im[0] = i_X0_im;
   assign in_im[1] = i_X1_im;
   assign in_im[2] = i_X2_im;
   assign in_im[3] = i_X3_im;
   assign in_im[4] = i_X4_im;
   assign in_im[5] = i_X5_im;
   assign in_im[6] = i_X6_im;
   assign in_im[7] = i_X7_im;

   assign o_mag0 = mag_q[0];
   assign o_mag1 = mag_q[1];
   assign o_mag2 = mag_q[2];
   assign o_mag3 = mag_q[3];
   assign o_mag4 = mag_q[4];
   assign o_mag5 = mag_q[5];
   assign o_mag6 = mag_q[6];
   assign o_mag7 = mag_q[7];

   assign o_dbg_state = state;

   // Widening to 33 bits first makes |-2^31| = 2^31 exact.
   function automatic logic [32:0] abs33(input logic [31:0] v);
      logic [32:0] ext;
      ext = {v[31], v};
      return v[31] ? (~ext + 33'd1) : ext;
   endfunction

   always_comb begin
      abs_re     = abs33(lat_re[cnt]);
      abs_im     = abs33(lat_im[cnt]);
      mx         = (abs_re >= abs_im) ? abs_re : abs_im;
      mn         = (abs_re >= abs_im) ? abs_im : abs_re;
      cur_mag    = mx + (mn >> 2) + (mn >> 3);
      in_range   = !(P_SKIP_DC && (cnt == 3'd0));
      nxt_pk_mag = pk_mag;
      nxt_pk_idx = pk_idx;
      // Strict compare keeps the lowest index on ties.
      if (in_range && (cur_mag > pk_mag)) begin
         nxt_pk_mag = cur_mag;
         nxt_pk_idx = cnt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= ST_IDLE;
         cnt        <= 3'd0;
         pk_mag     <= 33'd0;
         pk_idx     <= 3'd0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_peak_idx <= 3'd0;
         o_peak_mag <= 33'd0;
         for (int k = 0; k < 8; k++) begin
            lat_re[k] <= 32'd0;
            lat_im[k] <= 32'd0;
            mag_q[k]  <= 33'd0;
         end
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  for (int k = 0; k < 8; k++) begin
                     lat_re[k] <= in_re[k];
                     lat_im[k] <= in_im[k];
                  end
                  pk_mag <= 33'd0;
                  pk_idx <= P_SKIP_DC ? 3'd1 : 3'd0;
                  cnt    <= 3'd0;
                  o_busy <= 1'b1;
                  state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               mag_q[cnt] <= cur_mag;
               pk_mag     <= nxt_pk_mag;
               pk_idx     <= nxt_pk_idx;
               if (cnt == 3'd7) begin
                  o_peak_idx <= nxt_pk_idx;
                  o_peak_mag <= nxt_pk_mag;
                  o_busy     <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            ST_DONE: begin
               o_done <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft8_mag_peak.sv
// Directed bench for fft8_mag_peak: two instances (DC skipped / DC searched)
// share stimulus; a vector table plus handshake and mid-scan reset sequences.
module tb_fft8_mag_peak;

   typedef struct {
      logic [7:0][31:0] re;
      logic [7:0][31:0] im;
      logic [7:0][32:0] mag;
      logic [2:0]       idx1;
      logic [32:0]      pk1;
      logic [2:0]       idx0;
      logic [32:0]      pk0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic [31:0] re [8];
   logic [31:0] im [8];

   wire [32:0] mag_a [8];
   wire [32:0] mag_b [8];
   wire        busy_a, done_a, busy_b, done_b;
   wire [2:0]  idx_a, idx_b;
   wire [32:0] pk_a, pk_b;
   wire [1:0]  st_a, st_b;

   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   logic [2:0]  prev_idx_a = 3'd0;
   logic [32:0] prev_pk_a = 33'd0;
   vec_t vecs [8];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   fft8_mag_peak #(.P_SKIP_DC(1'b1)) u_dut (
      .i_clk(clk), .i_rstn(rstn), .i_start(start),
      .i_X0_re(re[0]), .i_X1_re(re[1]), .i_X2_re(re[2]), .i_X3_re(re[3]),
      .i_X4_re(re[4]), .i_X5_re(re[5]), .i_X6_re(re[6]), .i_X7_re(re[7]),
      .i_X0_im(im[0]), .i_X1_im(im[1]), .i_X2_im(im[2]), .i_X3_im(im[3]),
      .i_X4_im(im[4]), .i_X5_im(im[5]), .i_X6_im(im[6]), .i_X7_im(im[7]),
      .o_busy(busy_a), .o_done(done_a),
      .o_mag0(mag_a[0]), .o_mag1(mag_a[1]), .o_mag2(mag_a[2]), .o_mag3(mag_a[3]),
      .o_mag4(mag_a[4]), .o_mag5(mag_a[5]), .o_mag6(mag_a[6]), .o_mag7(mag_a[7]),
      .o_peak_idx(idx_a), .o_peak_mag(pk_a), .o_dbg_state(st_a)
   );

   fft8_mag_peak #(.P_SKIP_DC(1'b0)) u_dut_dc (
      .i_clk(clk), .i_rstn(rstn), .i_start(start),
      .i_X0_re(re[0]), .i_X1_re(re[1]), .i_X2_re(re[2]), .i_X3_re(re[3]),
      .i_X4_re(re[4]), .i_X5_re(re[5]), .i_X6_re(re[6]), .i_X7_re(re[7]),
      .i_X0_im(im[0]), .i_X1_im(im[1]), .i_X2_im(im[2]), .i_X3_im(im[3]),
      .i_X4_im(im[4]), .i_X5_im(im[5]), .i_X6_im(im[6]), .i_X7_im(im[7]),
      .o_busy(busy_b), .o_done(done_b),
      .o_mag0(mag_b[0]), .o_mag1(mag_b[1]), .o_mag2(mag_b[2]), .o_mag3(mag_b[3]),
      .o_mag4(mag_b[4]), .o_mag5(mag_b[5]), .o_mag6(mag_b[6]), .o_mag7(mag_b[7]),
      .o_peak_idx(idx_b), .o_peak_mag(pk_b), .o_dbg_state(st_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      for (int k = 0; k < 8; k++) begin
         re[k] = v.re[k];
         im[k] = v.im[k];
      end
   endtask

   task automatic check_results(input vec_t v, input string tag);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s mag_a%0d", tag, k), mag_a[k], v.mag[k]);
         chk($sformatf("%s mag_b%0d", tag, k), mag_b[k], v.mag[k]);
      end
      chk({tag, " peak_idx skipdc"}, idx_a, v.idx1);
      chk({tag, " peak_mag skipdc"}, pk_a, v.pk1);
      chk({tag, " peak_idx withdc"}, idx_b, v.idx0);
      chk({tag, " peak_mag withdc"}, pk_b, v.pk0);
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int da;
      int db;
      da = done_cnt_a;
      db = done_cnt_b;
      drive(v);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy after E0"}, busy_a, 1'b1);
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (e == 4) begin
            chk({tag, " peak_idx stable mid-scan"}, idx_a, prev_idx_a);
            chk({tag, " peak_mag stable mid-scan"}, pk_a, prev_pk_a);
         end
         if (e == 7) chk({tag, " busy after E7"}, busy_a, 1'b1);
      end
      chk({tag, " busy_a after E8"}, busy_a, 1'b0);
      chk({tag, " busy_b after E8"}, busy_b, 1'b0);
      chk({tag, " done after E8"}, done_a, 1'b0);
      chk({tag, " peak_idx after E8"}, idx_a, v.idx1);
      @(posedge clk); #1;
      chk({tag, " done_a after E9"}, done_a, 1'b1);
      chk({tag, " done_b after E9"}, done_b, 1'b1);
      check_results(v, tag);
      @(posedge clk); #1;
      chk({tag, " done after E10"}, done_a, 1'b0);
      chk({tag, " state idle after E10"}, st_a, 2'd0);
      chk({tag, " done_a pulses"}, done_cnt_a - da, 1);
      chk({tag, " done_b pulses"}, done_cnt_b - db, 1);
      prev_idx_a = v.idx1;
      prev_pk_a  = v.pk1;
   endtask

   initial begin
      int da;
      for (int i = 0; i < 8; i++) vecs[i] = '{default: '0};
      // flat spectrum, ties go to the lowest searched index
      for (int k = 0; k < 8; k++) begin
         vecs[0].re[k]  = 32'd100;
         vecs[0].mag[k] = 33'd100;
      end
      vecs[0].idx1 = 3'd1; vecs[0].pk1 = 33'd100;
      vecs[0].idx0 = 3'd0; vecs[0].pk0 = 33'd100;
      // X3 = (-300, 400): 400 + 75 + 37
      vecs[1].re[3] = -32'd300; vecs[1].im[3] = 32'd400; vecs[1].mag[3] = 33'd512;
      vecs[1].idx1 = 3'd3; vecs[1].pk1 = 33'd512; vecs[1].idx0 = 3'd3; vecs[1].pk0 = 33'd512;
      // X5 = (-7, 0)
      vecs[2].re[5] = -32'd7; vecs[2].mag[5] = 33'd7;
      vecs[2].idx1 = 3'd5; vecs[2].pk1 = 33'd7; vecs[2].idx0 = 3'd5; vecs[2].pk0 = 33'd7;
      // X6 = (-2^31, -2^31): 2^31 + 2^29 + 2^28
      vecs[3].re[6] = 32'h8000_0000; vecs[3].im[6] = 32'h8000_0000;
      vecs[3].mag[6] = 33'd2952790016;
      vecs[3].idx1 = 3'd6; vecs[3].pk1 = 33'd2952790016;
      vecs[3].idx0 = 3'd6; vecs[3].pk0 = 33'd2952790016;
      // X2 = (2^31-1, 0)
      vecs[4].re[2] = 32'h7FFF_FFFF; vecs[4].mag[2] = 33'd2147483647;
      vecs[4].idx1 = 3'd2; vecs[4].pk1 = 33'd2147483647;
      vecs[4].idx0 = 3'd2; vecs[4].pk0 = 33'd2147483647;
      // DC handling: X0 = (1000, 0), X4 = (0, 500)
      vecs[5].re[0] = 32'd1000; vecs[5].im[4] = 32'd500;
      vecs[5].mag[0] = 33'd1000; vecs[5].mag[4] = 33'd500;
      vecs[5].idx1 = 3'd4; vecs[5].pk1 = 33'd500; vecs[5].idx0 = 3'd0; vecs[5].pk0 = 33'd1000;
      // all zero: peak stays at its cleared value
      vecs[6].idx1 = 3'd1; vecs[6].pk1 = 33'd0; vecs[6].idx0 = 3'd0; vecs[6].pk0 = 33'd0;
      // X0 = (20,0), X1 = (-14,0), X7 = (5,-13): 13 + 1 + 0 = 14 ties bin 1
      vecs[7].re[0] = 32'd20; vecs[7].re[1] = -32'd14;
      vecs[7].re[7] = 32'd5;  vecs[7].im[7] = -32'd13;
      vecs[7].mag[0] = 33'd20; vecs[7].mag[1] = 33'd14; vecs[7].mag[7] = 33'd14;
      vecs[7].idx1 = 3'd1; vecs[7].pk1 = 33'd14; vecs[7].idx0 = 3'd0; vecs[7].pk0 = 33'd20;

      for (int k = 0; k < 8; k++) begin
         re[k] = 32'd0;
         im[k] = 32'd0;
      end

      // power-on reset
      #2 rstn = 1'b0;
      #1;
      chk("reset busy", busy_a, 1'b0);
      chk("reset done", done_a, 1'b0);
      chk("reset peak_idx", idx_a, 3'd0);
      chk("reset peak_mag", pk_a, 33'd0);
      chk("reset state", st_a, 2'd0);
      chk("reset mag0", mag_a[0], 33'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // extra starts during scan and in ST_DONE are dropped
      da = done_cnt_a;
      drive(vecs[1]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         if (e == 2) begin
            drive(vecs[2]);
            start = 1'b1;
         end
         if (e == 3) start = 1'b0;
         if (e == 8) begin
            drive(vecs[3]);
            start = 1'b1;
         end
         if (e == 9) begin
            start = 1'b0;
            chk("hs done after E9", done_a, 1'b1);
         end
      end
      chk("hs busy after E10", busy_a, 1'b0);
      chk("hs state idle after E10", st_a, 2'd0);
      chk("hs single done", done_cnt_a - da, 1);
      check_results(vecs[1], "hs first frame");
      prev_idx_a = vecs[1].idx1;
      prev_pk_a  = vecs[1].pk1;
      run_frame(vecs[3], "hs start at E11");

      // reset in the middle of a scan
      drive(vecs[0]);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("midrst busy", busy_a, 1'b0);
      chk("midrst done", done_a, 1'b0);
      chk("midrst peak_idx", idx_a, 3'd0);
      chk("midrst peak_mag", pk_a, 33'd0);
      chk("midrst state", st_a, 2'd0);
      for (int k = 0; k < 8; k++) chk($sformatf("midrst mag%0d", k), mag_a[k], 33'd0);
      da = done_cnt_a;
      @(negedge clk);
      rstn = 1'b1;
      prev_idx_a = 3'd0;
      prev_pk_a  = 33'd0;
      repeat (12) @(negedge clk);
      chk("midrst no done", done_cnt_a - da, 0);
      chk("midrst busy after release", busy_a, 1'b0);
      chk("midrst idle after release", st_a, 2'd0);
      run_frame(vecs[5], "after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
